// File: rtl/axi_common_pkg.sv
// Shared AXI mux helpers: round-robin search used by both the write- and
// read-side arbiters.
package axi_common;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;
  localparam int unsigned RR_CAND_W  = RR_IDX_W + 1;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // Search ptr, ptr+1, ... modulo n; idx is 0 when nothing is requested.
  function automatic rr_result_t rr_next(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [RR_IDX_W-1:0]   ptr,
    input int unsigned           n
  );
    rr_result_t           res;
    logic [RR_CAND_W-1:0] cand;
    logic                 hit;
    res.found = 1'b0;
    res.idx   = {RR_IDX_W{1'b0}};
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      cand = {1'b0, ptr} + RR_CAND_W'(k);
      cand = (cand >= RR_CAND_W'(n)) ? (cand - RR_CAND_W'(n)) : cand;
      hit  = (k < n) && !res.found && req[cand[RR_IDX_W-1:0]];
      res.idx   = hit ? cand[RR_IDX_W-1:0] : res.idx;
      res.found = res.found | hit;
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter with AXI-style grant lock: once valid is shown without
// ready, the same index is held until the handshake completes.
module axi_rr_arbiter
  import axi_common::*;
#(
  parameter int unsigned  N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [N-1:0]  req,
  input  logic          ready,
  output logic          valid,
  output logic [IW-1:0] grant
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] hold_r;
  logic          lock_r;
  logic          hs_s;
  rr_result_t    rr_s;

  // Winner selection; a held grant overrides the live search.
  always_comb begin
    rr_s = rr_next(RR_MAX_REQ'(req), RR_IDX_W'(ptr_r), N);
    if (lock_r) begin
      valid = 1'b1;
      grant = hold_r;
    end else begin
      valid = rr_s.found;
      grant = IW'(rr_s.idx);
    end
  end

  assign hs_s = valid & ready;

  // Priority pointer and lock/hold state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_r  <= {IW{1'b0}};
      hold_r <= {IW{1'b0}};
      lock_r <= 1'b0;
    end else if (hs_s) begin
      ptr_r  <= (grant == IW'(N - 1)) ? {IW{1'b0}} : (grant + IW'(1));
      lock_r <= 1'b0;
    end else if (valid) begin
      hold_r <= grant;
      lock_r <= 1'b1;
    end
  end

endmodule

// File: rtl/axi_mux_write_arbiter.sv
// Write-path controller of an N-to-1 AXI mux: arbitrates AW, remembers grant
// order in a small FIFO and steers W from the head-of-FIFO master.
module axi_mux_write_arbiter
  import axi_common::*;
#(
  parameter int unsigned  MASTER_NUM = 2,
  parameter int unsigned  FIFO_DEPTH = 4,
  localparam int unsigned IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MASTER_NUM-1:0] m_aw_valid,
  output logic [MASTER_NUM-1:0] m_aw_ready,
  output logic                  s_aw_valid,
  input  logic                  s_aw_ready,
  output logic [IDX_W-1:0]      aw_sel,
  input  logic [MASTER_NUM-1:0] m_w_valid,
  input  logic [MASTER_NUM-1:0] m_w_last,
  output logic [MASTER_NUM-1:0] m_w_ready,
  output logic                  s_w_valid,
  input  logic                  s_w_ready,
  output logic [IDX_W-1:0]      w_sel,
  output logic                  w_sel_valid
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [MASTER_NUM-1:0] req_masked_s;
  logic                  arb_valid_s;
  logic [IDX_W-1:0]      arb_idx_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic                  fifo_full_s;
  logic [IDX_W-1:0]      head_s;
  logic [PW-1:0]         wptr_r;
  logic [PW-1:0]         rptr_r;
  logic [IDX_W-1:0]      fifo_mem_r [FIFO_DEPTH];

  assign fifo_empty_s = (wptr_r == rptr_r);
  assign fifo_full_s  = (wptr_r[PW-1] != rptr_r[PW-1]) &&
                        (wptr_r[PW-2:0] == rptr_r[PW-2:0]);
  assign head_s       = fifo_mem_r[rptr_r[PW-2:0]];

  // A full FIFO hides new requests; an already locked grant stays visible.
  always_comb begin
    if (fifo_full_s) begin
      req_masked_s = {MASTER_NUM{1'b0}};
    end else begin
      req_masked_s = m_aw_valid;
    end
  end

  axi_rr_arbiter #(
    .N (MASTER_NUM)
  ) u_aw_arb (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req_masked_s),
    .ready (s_aw_ready),
    .valid (arb_valid_s),
    .grant (arb_idx_s)
  );

  // Handshake/select outputs; gated by rstn so they read 0 during reset.
  always_comb begin
    s_aw_valid  = rstn & arb_valid_s;
    aw_sel      = rstn ? arb_idx_s : {IDX_W{1'b0}};
    w_sel_valid = rstn & ~fifo_empty_s;
    w_sel       = w_sel_valid ? head_s : {IDX_W{1'b0}};
    s_w_valid   = w_sel_valid & m_w_valid[w_sel];
    push_s      = s_aw_valid & s_aw_ready;
    pop_s       = s_w_valid & s_w_ready & m_w_last[w_sel];
    m_aw_ready  = {MASTER_NUM{1'b0}};
    m_w_ready   = {MASTER_NUM{1'b0}};
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_aw_ready[i] = push_s & (aw_sel == IDX_W'(i));
      m_w_ready[i]  = w_sel_valid & (w_sel == IDX_W'(i)) & s_w_ready;
    end
  end

  // Grant-order FIFO; the head is only read from the cycle after a push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_r <= {PW{1'b0}};
      rptr_r <= {PW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {IDX_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r[PW-2:0]] <= aw_sel;
        wptr_r                     <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
    end
  end

endmodule

// File: doc/axi_mux_write_arbiter.md
Name: axi_mux_write_arbiter

Overview:
Controller for the write path of an N-to-1 AXI mux.
- Round-robin arbitrates AW requests from MASTER_NUM upstream ports onto one downstream AW channel.
- Records each granted master index in an ordering FIFO.
- Steers the W channel from the head-of-FIFO master until WLAST, so write data stays in AW order.
- Drives only handshake and select signals; payload muxing lives in the mux datapath, which uses aw_sel and w_sel.

Parameters:
MASTER_NUM, 2, number of upstream masters (>=2).
FIFO_DEPTH, 4, number of outstanding AW grants whose W bursts are not yet complete (power of two, >=2).
IDX_W, $clog2(MASTER_NUM), width of master index (derived, not overridable).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
m_aw_valid  in  MASTER_NUM  per-master AWVALID
m_aw_ready  out  MASTER_NUM  per-master AWREADY
s_aw_valid  out  1  downstream AWVALID
s_aw_ready  in  1  downstream AWREADY
aw_sel  out  IDX_W  master whose AW payload is forwarded
m_w_valid  in  MASTER_NUM  per-master WVALID
m_w_last  in  MASTER_NUM  per-master WLAST
m_w_ready  out  MASTER_NUM  per-master WREADY
s_w_valid  out  1  downstream WVALID
s_w_ready  in  1  downstream WREADY
w_sel  out  IDX_W  master whose W payload is forwarded
w_sel_valid  out  1  FIFO non-empty (w_sel meaningful)

Behaviour:
Reset:
- While rstn low: FIFO empty, RR pointer 0, lock clear.
- All outputs 0: s_aw_valid, m_aw_ready, s_w_valid, m_w_ready, aw_sel, w_sel, w_sel_valid.

AW arbitration:
- Requests are m_aw_valid, masked to zero when the FIFO is full.
- Round-robin: highest priority is index ptr; search ptr, ptr+1, ... wrapping modulo MASTER_NUM.
- Arbitration is combinational when unlocked; s_aw_valid = any masked request; aw_sel = winner.
- If s_aw_valid && !s_aw_ready, register lock=1 and held index. While locked, aw_sel = held index and s_aw_valid = 1 regardless of other requests (AXI stability).
- m_aw_ready[i] = s_aw_ready && s_aw_valid && (aw_sel==i). Zero-cycle AW latency.
- On AW handshake: push aw_sel into FIFO, ptr <= aw_sel+1 (wrapping to 0 after MASTER_NUM-1), lock clear.

W steering:
- w_sel = FIFO head; w_sel_valid = !empty.
- s_w_valid = w_sel_valid && m_w_valid[w_sel].
- m_w_ready[i] = w_sel_valid && (w_sel==i) && s_w_ready.
- No bypass: a burst's first beat may transfer at the earliest the cycle after its AW handshake.
- W handshake with m_w_last[w_sel]=1 pops the FIFO at the clock edge.
- Beats from non-selected masters are held (ready=0).

FIFO:
- Circular buffer with read/write pointers of $clog2(FIFO_DEPTH)+1 bits.
- Full when the MSBs differ and the low bits are equal.
- Simultaneous push and pop when full: push is already blocked by masking, so only the pop occurs; full clears next cycle.
- Simultaneous push and pop when non-full: occupancy unchanged, both pointers advance.
- Pointers wrap naturally.

Boundaries:
- A full FIFO never drops an in-flight locked AW: the lock only forms once a request has passed the mask, and lock forces s_aw_valid irrespective of full.
- Reset mid-burst discards all state; no partial-burst recovery.

Decomposition:
- Shared package axi_common gains a function rr_next(req, ptr) returning the winning index and a found flag, usable by the read-side arbiter.
- Natural sub-module: axi_rr_arbiter (request vector, pointer, lock/hold, grant index). The read arbiter will reuse it.
- FIFO control stays inline.

Test Plan:
1. MASTER_NUM=4; m_aw_valid=4'b1111, s_aw_ready=1 every cycle -> aw_sel sequence 0,1,2,3,0; each m_aw_ready one-hot; FIFO contents 0,1,2,3.
2. m_aw_valid=4'b0110, s_aw_ready=0 for 3 cycles then 1 -> aw_sel stays 1 all 4 cycles even with m_aw_valid[3] asserted on cycle 2; handshake on cycle 4; next grant 2.
3. FIFO_DEPTH=2; two AW handshakes (masters 2,0), no W -> third AW request sees s_aw_valid=0; a WLAST beat from master 2 pops; next cycle the AW is granted.
4. AWs granted to 1 then 3; master 3 presents W first, master 1 sends 4-beat burst -> master 3 stalled (m_w_ready[3]=0) until master 1's WLAST; then w_sel=3.
5. Push and pop in the same cycle at occupancy 1 -> occupancy stays 1; w_sel advances to the new entry next cycle.
6. Assert rstn=0 mid-burst with FIFO holding 2 entries -> all outputs 0 asynchronously; after release, w_sel_valid=0 and aw_sel priority starts at master 0.
